end_screen_drawer: RTL and testbench

- Parametrised, animated successor to the static game-over tile screen.
- Draws a win (smile) or lose (frown) face into the background tile map: a top-to-bottom wipe, then a hold phase with eye blinking.
- Waits for a jump press, then requests a restart.
- Sits between the game-state controller and the tile renderer, all in the vga_clock domain.

---
 rtl/end_screen_drawer.sv | 136 +++++++++++++
 tb/tb_end_screen_drawer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/end_screen_drawer.sv
// Animated win/lose face on the background tile map: a top-down wipe, a hold with eye blinks, then a restart request on a jump press.
// Optional build macro END_SCREEN_AUTO_RESTART_EN adds a timed restart out of HOLD.
module end_screen_drawer #(
  parameter int ROWS         = 12,
  parameter int COLS         = 17,
  parameter int BDR          = 0,
  parameter int FACE         = 1,
  parameter int TICK_CYCLES  = 1250000,
  parameter int BLINK_PERIOD = 20,
  parameter int AUTO_TICKS   = 200
) (
  input  logic                              vga_clock,
  input  logic                              reset,
  input  logic                              start,
  input  logic                              win_mode,
  input  logic                              jump_button,
  output logic [ROWS-1:0][COLS-1:0][7:0]    background,
  output logic                              busy,
  output logic                              restart_req
);
  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int RW = $clog2(ROWS + 1);
  localparam int HW = $clog2(BLINK_PERIOD);
  localparam int C  = COLS / 2;

  typedef enum logic [1:0] {S_IDLE, S_WIPE, S_HOLD, S_EXIT} state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   cnt_q, cnt_d;
  logic [RW-1:0]   rows_q, rows_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic            mode_q, mode_d;
  logic            jump_prev_q, jump_prev_d;
  logic            tick, jump_edge, blink;
`ifdef END_SCREEN_AUTO_RESTART_EN
  localparam int AW = $clog2(AUTO_TICKS + 1);
  logic [AW-1:0]   idle_q, idle_d;
`endif

  function automatic logic is_eye(input int r, input int c);
    return (r >= 1 && r <= 3) &&
           ((c >= C-6 && c <= C-4) || (c >= C+4 && c <= C+6));
  endfunction

  // Mouth tiles are symmetric about C, so match on distance from the centre column.
  function automatic logic is_mouth(input int r, input int c, input logic smile);
    int ad;
    ad = (c < C) ? C - c : c - C;
    if (smile)
      return ((r == 5 || r == 6) && ad == 5) || ((r == 7 || r == 8) && ad == 4) ||
             (r == 9 && ad == 3) || (r == 10 && ad <= 2);
    else
      return (r == 5 && ad <= 2) || (r == 6 && ad == 3) ||
             ((r == 7 || r == 8) && ad == 4) || ((r == 9 || r == 10) && ad == 5);
  endfunction

  assign tick      = (state_q != S_IDLE) && (cnt_q == TW'(TICK_CYCLES - 1));
  assign jump_edge = jump_button && !jump_prev_q;

  always_ff @(posedge vga_clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rows_q      <= '0;
      hold_q      <= '0;
      mode_q      <= 1'b0;
      jump_prev_q <= 1'b0;
`ifdef END_SCREEN_AUTO_RESTART_EN
      idle_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rows_q      <= rows_d;
      hold_q      <= hold_d;
      mode_q      <= mode_d;
      jump_prev_q <= jump_prev_d;
`ifdef END_SCREEN_AUTO_RESTART_EN
      idle_q      <= idle_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rows_d      = rows_q;
    hold_d      = hold_q;
    mode_d      = mode_q;
    jump_prev_d = jump_button;
`ifdef END_SCREEN_AUTO_RESTART_EN
    idle_d      = idle_q;
`endif
    if (state_q != S_IDLE) cnt_d = tick ? '0 : cnt_q + 1'b1;
    case (state_q)
      S_IDLE: if (start) begin
        mode_d  = win_mode;
        rows_d  = '0;
        hold_d  = '0;
        cnt_d   = '0;
        state_d = S_WIPE;
      end
      S_WIPE: if (tick) begin
        rows_d = rows_q + 1'b1;
        if (rows_q == RW'(ROWS - 1)) begin
          state_d = S_HOLD;
`ifdef END_SCREEN_AUTO_RESTART_EN
          idle_d  = '0;
`endif
        end
      end
      S_HOLD: begin
        if (tick) hold_d = (hold_q == HW'(BLINK_PERIOD - 1)) ? '0 : hold_q + 1'b1;
`ifdef END_SCREEN_AUTO_RESTART_EN
        if (tick) idle_d = idle_q + 1'b1;
        if (jump_edge || (tick && idle_d == AW'(AUTO_TICKS))) state_d = S_EXIT;
`else
        if (jump_edge) state_d = S_EXIT;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy        = (state_q != S_IDLE);
    restart_req = (state_q == S_EXIT);
    blink       = (state_q == S_HOLD) && (hold_q == HW'(BLINK_PERIOD - 1));
    background  = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        background[r][c] =
          (((state_q == S_WIPE) ? (r < int'(rows_q)) : (state_q != S_IDLE)) &&
           ((is_eye(r, c) && !blink) || is_mouth(r, c, mode_q))) ? 8'(FACE) : 8'(BDR);
  end
endmodule

// File: tb/tb_end_screen_drawer.sv
// Bench for end_screen_drawer: elapsed-time reference model checked every cycle, plus literal pins.
module tb_end_screen_drawer;
  localparam int ROWS = 12, COLS = 17, T = 4, BP = 3, AT = 5, C = COLS / 2;

  logic vga_clock = 1'b0, reset = 1'b1, start = 1'b0, win_mode = 1'b0, jump_button = 1'b0;
  logic [ROWS-1:0][COLS-1:0][7:0] background;
  logic busy, restart_req;

  int n_vec = 0, n_err = 0, cyc = 0;
  bit eye[ROWS][COLS];
  bit mouth[2][ROWS][COLS];
  // model: ph 0 idle, 1 showing (k cycles since start accepted), 2 exit
  int ph = 0, k = 0;
  bit m_mode = 0, m_jp = 0;

  end_screen_drawer #(.ROWS(ROWS), .COLS(COLS), .BDR(0), .FACE(1), .TICK_CYCLES(T),
                      .BLINK_PERIOD(BP), .AUTO_TICKS(AT)) dut (
    .vga_clock(vga_clock), .reset(reset), .start(start), .win_mode(win_mode),
    .jump_button(jump_button), .background(background), .busy(busy), .restart_req(restart_req));

  always #5 vga_clock = ~vga_clock;

  task automatic mp(input int m, input int r, input int d);
    mouth[m][r][C-d] = 1'b1;
    mouth[m][r][C+d] = 1'b1;
  endtask

  function automatic bit exp_px(input int r, input int c);
    bit blink;
    if (ph == 0) return 1'b0;
    if (ph == 2) return eye[r][c] | mouth[m_mode][r][c];
    if (k < ROWS*T) return (r < k / T) && (eye[r][c] | mouth[m_mode][r][c]);
    blink = (((k - ROWS*T) / T) % BP) == BP - 1;
    return (eye[r][c] && !blink) | mouth[m_mode][r][c];
  endfunction

  task automatic model_edge(input bit s, input bit w, input bit j, input bit r);
    bit jedge;
    if (r) begin
      ph = 0; k = 0; m_mode = 0; m_jp = 0;
      return;
    end
    jedge = j && !m_jp;
    m_jp  = j;
    case (ph)
      0: if (s) begin m_mode = w; k = 0; ph = 1; end
      1: if (k >= ROWS*T && jedge) ph = 2;
         else begin
           k++;
`ifdef END_SCREEN_AUTO_RESTART_EN
           if (k == ROWS*T + AT*T) ph = 2;
`endif
         end
      default: ph = 0;
    endcase
  endtask

  task automatic compare();
    int br, bc;
    bit bad;
    bad = 0; br = -1; bc = -1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (!bad && background[r][c] != (exp_px(r, c) ? 8'd1 : 8'd0)) begin
          bad = 1; br = r; bc = c;
        end
    if (busy !== (ph != 0) || restart_req !== (ph == 2)) bad = 1;
    n_vec++;
    if (bad) begin
      n_err++;
      if (br >= 0)
        $display("FAIL model cyc=%0d tile[%0d][%0d] got %0d want %0d busy %0b/%0b req %0b/%0b",
                 cyc, br, bc, background[br][bc], exp_px(br, bc), busy, ph != 0, restart_req, ph == 2);
      else
        $display("FAIL model cyc=%0d busy got %0b want %0b req got %0b want %0b",
                 cyc, busy, ph != 0, restart_req, ph == 2);
    end
  endtask

  task automatic step(input bit s, input bit w, input bit j, input bit r);
    start = s; win_mode = w; jump_button = j; reset = r;
    @(posedge vga_clock);
    model_edge(s, w, j, r);
    cyc++;
    @(negedge vga_clock);
    compare();
  endtask

  task automatic lit(input string nm, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s cyc=%0d got %0d want %0d", nm, cyc, got, want);
    end
  endtask

  initial begin
    bit jb;
    for (int r = 1; r <= 3; r++)
      for (int d = 4; d <= 6; d++) begin eye[r][C-d] = 1; eye[r][C+d] = 1; end
    for (int d = 0; d <= 2; d++) begin mp(0, 5, d); mp(1, 10, d); end
    mp(0, 6, 3); mp(0, 7, 4); mp(0, 8, 4); mp(0, 9, 5); mp(0, 10, 5);
    mp(1, 5, 5); mp(1, 6, 5); mp(1, 7, 4); mp(1, 8, 4); mp(1, 9, 3);

    @(negedge vga_clock);
    repeat (3) step(0, 0, 0, 1);
    repeat (50) step(0, 0, 1'($urandom_range(0, 1)), 0);
    lit("idle_bg_zero", int'(background == '0), 1);
    lit("idle_busy", busy, 0);
    lit("idle_req", restart_req, 0);

    // lose wipe with jump held throughout and a stray win start mid-wipe
    step(1, 0, 1, 0);
    lit("wipe_busy", busy, 1);
    for (int i = 1; i <= 48; i++) begin
      step(i == 20, 1, 1, 0);
      if (i == 7) lit("row1_hidden", background[1][2], 0);
      if (i == 8) lit("row1_shown", background[1][2], 1);
    end
    for (int c = 6; c <= 10; c++) lit("frown_row5", background[5][c], 1);
    lit("frown_10_3", background[10][3], 1);
    lit("frown_10_13", background[10][13], 1);
    repeat (10) step(0, 0, 1, 0);
    lit("held_no_exit", restart_req, 0);
    lit("held_busy", busy, 1);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    lit("exit_pulse", restart_req, 1);
    step(0, 0, 1, 0);
    lit("exit_once", restart_req, 0);
    lit("after_busy", busy, 0);
    lit("after_bg_zero", int'(background == '0), 1);

    // win mode blink
    step(1, 1, 0, 0);
    repeat (48) step(0, 0, 0, 0);
    for (int i = 0; i < 12; i++) begin
      lit("blink_eye", background[2][2], (i < 8) ? 1 : 0);
      lit("smile_5_3", background[5][3], 1);
      step(0, 0, 0, 0);
    end
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);

    // reset mid-wipe
    step(1, 0, 0, 0);
    repeat (24) step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    lit("rst_bg_zero", int'(background == '0), 1);
    lit("rst_busy", busy, 0);
    step(0, 0, 0, 0);

`ifdef END_SCREEN_AUTO_RESTART_EN
    step(1, 0, 0, 0);
    repeat (48) step(0, 0, 0, 0);
    for (int i = 1; i <= 21; i++) begin
      step(0, 0, 0, 0);
      lit("auto_req", restart_req, (i == 20) ? 1 : 0);
    end
`endif

    jb = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 9) == 0) jb = ~jb;
      step($urandom_range(0, 15) == 0, 1'($urandom_range(0, 1)), jb, $urandom_range(0, 499) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
